// File: rtl/tamagotchi_stat_bank.sv
// rtl/tamagotchi_stat_bank.sv - saturating bank of pet-status registers with flags and optional decay
//
// Purpose: NUM_STATS saturating WIDTH-bit counters (hunger, energy, mood, ...).
//   The control FSM selects a channel and issues up/down/load requests.
//   The display and alert logic reads the selected value and the registered flags.
// Build option: define TAMA_STATS_DECAY_EN to build the periodic decay timer.
//   When it is left undefined, decay_en is accepted but ignored.
// Ports:
//   clk        - rising-edge clock
//   Reset      - synchronous active-low reset
//   state      - channel select for read, up/down and load
//   UpState    - add STEP to the selected channel
//   DownState  - subtract STEP from the selected channel
//   wr_en      - load wr_data (clipped to MAX_VAL) into the selected channel
//   wr_data    - load value
//   decay_en   - gates the decay timer
//   stateValue - combinational read of the selected channel (0 when state is out of range)
//   low_flags  - registered, bit i set when channel i <= LOW_THRESH
//   any_low    - registered OR of low_flags
//   all_zero   - registered, every channel is 0
//   sat_evt    - registered one-cycle pulse when an up/down request was clipped
module tamagotchi_stat_bank #(
  parameter int NUM_STATS = 7,
  parameter int WIDTH = 3,
  parameter int IDX_W = 3,
  parameter int STEP = 1,
  parameter int MAX_VAL = (1 << WIDTH) - 1,
  parameter logic [NUM_STATS*WIDTH-1:0] INIT_VAL = '0,
  parameter int LOW_THRESH = 1,
  parameter int DECAY_PERIOD = 1000
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic [IDX_W-1:0]     state,
  input  logic                 UpState,
  input  logic                 DownState,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 decay_en,
  output logic [WIDTH-1:0]     stateValue,
  output logic [NUM_STATS-1:0] low_flags,
  output logic                 any_low,
  output logic                 all_zero,
  output logic                 sat_evt
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] LOW_V = WIDTH'(LOW_THRESH);
  // Two extra bits: one for headroom above MAX_VAL, one for sign.
  localparam logic signed [WIDTH+1:0] STEP_S = (WIDTH+2)'(STEP);
  localparam logic signed [WIDTH+1:0] MAX_S  = (WIDTH+2)'(MAX_VAL);
  localparam logic signed [WIDTH+1:0] ONE_S  = (WIDTH+2)'(1);
  localparam logic signed [WIDTH+1:0] ZERO_S = '0;

  logic [WIDTH-1:0]          vals      [NUM_STATS];
  logic [WIDTH-1:0]          nxt       [NUM_STATS];
  logic signed [WIDTH+1:0]   user_sum  [NUM_STATS];
  logic signed [WIDTH+1:0]   tot_sum   [NUM_STATS];
  logic [NUM_STATS-1:0]      sel;
  logic [NUM_STATS-1:0]      low_nxt;
  logic [NUM_STATS-1:0]      init_low;
  logic                      zero_nxt;
  logic                      init_zero;
  logic                      sat_nxt;
  logic                      tick;
  logic                      up_only;
  logic                      dn_only;

  assign up_only = UpState && !DownState;
  assign dn_only = DownState && !UpState;

`ifdef TAMA_STATS_DECAY_EN
  localparam int CNT_W = $clog2(DECAY_PERIOD);
  logic [CNT_W-1:0] dcnt;

  // The counter holds while disabled, so the tick is gated as well.
  assign tick = decay_en && (dcnt == CNT_W'(DECAY_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (!Reset) begin
      dcnt <= '0;
    end else if (decay_en) begin
      dcnt <= tick ? '0 : dcnt + 1'b1;
    end
  end
`else
  logic unused_decay_en;
  assign unused_decay_en = decay_en;
  assign tick = 1'b0;
`endif

  // Reset-time flags come straight from the INIT_VAL parameter.
  always_comb begin
    init_low  = '0;
    init_zero = 1'b1;
    for (int i = 0; i < NUM_STATS; i++) begin
      init_low[i] = (INIT_VAL[i*WIDTH +: WIDTH] <= LOW_V);
      if (INIT_VAL[i*WIDTH +: WIDTH] != '0) init_zero = 1'b0;
    end
  end

  always_comb begin
    sat_nxt    = 1'b0;
    zero_nxt   = 1'b1;
    low_nxt    = '0;
    sel        = '0;
    stateValue = '0;
    for (int i = 0; i < NUM_STATS; i++) begin
      // Out-of-range selects never match a channel, so requests are ignored.
      sel[i] = (state == IDX_W'(i));
      if (sel[i]) stateValue = vals[i];
      user_sum[i] = $signed({2'b00, vals[i]})
                  + ((sel[i] && up_only) ? STEP_S : ((sel[i] && dn_only) ? -STEP_S : ZERO_S));
      tot_sum[i] = user_sum[i] - (tick ? ONE_S : ZERO_S);
      if (sel[i] && wr_en) begin
        nxt[i] = (wr_data > MAX_V) ? MAX_V : wr_data;
      end else begin
        if (tot_sum[i] < ZERO_S)      nxt[i] = '0;
        else if (tot_sum[i] > MAX_S)  nxt[i] = MAX_V;
        else                          nxt[i] = tot_sum[i][WIDTH-1:0];
        // Only the user's own request counts as clipped; decay at zero is silent.
        if (sel[i] && (user_sum[i] < ZERO_S || user_sum[i] > MAX_S)) sat_nxt = 1'b1;
      end
      low_nxt[i] = (nxt[i] <= LOW_V);
      if (nxt[i] != '0) zero_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_STATS; i++) vals[i] <= INIT_VAL[i*WIDTH +: WIDTH];
      low_flags <= init_low;
      any_low   <= |init_low;
      all_zero  <= init_zero;
      sat_evt   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_STATS; i++) vals[i] <= nxt[i];
      low_flags <= low_nxt;
      any_low   <= |low_nxt;
      all_zero  <= zero_nxt;
      sat_evt   <= sat_nxt;
    end
  end

endmodule

// File: tb/tb_tamagotchi_stat_bank.sv
// tb/tb_tamagotchi_stat_bank.sv - self-checking bench for tamagotchi_stat_bank
module tb_tamagotchi_stat_bank;

  localparam int N = 7;
  localparam int PER = 4;
`ifdef TAMA_STATS_DECAY_EN
  localparam bit DECAY = 1'b1;
`else
  localparam bit DECAY = 1'b0;
`endif

  logic clk = 1'b0;
  logic Reset = 1'b0;
  logic [2:0] state = '0;
  logic UpState = 1'b0;
  logic DownState = 1'b0;
  logic wr_en = 1'b0;
  logic [2:0] wr_data = '0;
  logic decay_en = 1'b0;
  logic [2:0] stateValue;
  logic [N-1:0] low_flags;
  logic any_low;
  logic all_zero;
  logic sat_evt;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tamagotchi_stat_bank #(
    .NUM_STATS(7), .WIDTH(3), .IDX_W(3), .STEP(1), .MAX_VAL(7),
    .INIT_VAL({3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}),
    .LOW_THRESH(1), .DECAY_PERIOD(PER)
  ) dut (
    .clk(clk), .Reset(Reset), .state(state), .UpState(UpState), .DownState(DownState),
    .wr_en(wr_en), .wr_data(wr_data), .decay_en(decay_en), .stateValue(stateValue),
    .low_flags(low_flags), .any_low(any_low), .all_zero(all_zero), .sat_evt(sat_evt)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: plain integer stat values and a cycle counter.
  int m[N];
  int mcnt;
  bit msat;
  bit mvalid = 1'b0;

  always @(posedge clk) begin
    int u;
    int t;
    bit tk;
    if (!Reset) begin
      for (int i = 0; i < N; i++) m[i] = i;
      mcnt = 0;
      msat = 1'b0;
      mvalid = 1'b1;
    end else if (mvalid) begin
      tk = DECAY && decay_en && (mcnt == PER - 1);
      if (DECAY && decay_en) mcnt = tk ? 0 : mcnt + 1;
      msat = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (int'(state) == i && wr_en) begin
          m[i] = (int'(wr_data) > 7) ? 7 : int'(wr_data);
        end else begin
          u = m[i];
          if (int'(state) == i && UpState && !DownState) u = u + 1;
          if (int'(state) == i && DownState && !UpState) u = u - 1;
          if (u < 0 || u > 7) msat = 1'b1;
          t = u - (tk ? 1 : 0);
          m[i] = (t < 0) ? 0 : ((t > 7) ? 7 : t);
        end
      end
    end
  end

  always @(negedge clk) begin
    int exp_low;
    int exp_zero;
    if (mvalid) begin
      exp_low = 0;
      exp_zero = 1;
      for (int i = 0; i < N; i++) begin
        if (m[i] <= 1) exp_low = exp_low | (1 << i);
        if (m[i] != 0) exp_zero = 0;
      end
      chk("stateValue", int'(stateValue), (int'(state) < N) ? m[state] : 0);
      chk("low_flags", int'(low_flags), exp_low);
      chk("any_low", int'(any_low), int'(exp_low != 0));
      chk("all_zero", int'(all_zero), exp_zero);
      chk("sat_evt", int'(sat_evt), int'(msat));
    end
  end

  task automatic clr();
    UpState = 1'b0; DownState = 1'b0; wr_en = 1'b0;
  endtask

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset and reset-value sweep
    edge1();
    Reset = 1'b1;
    for (int s = 0; s < N; s++) begin
      state = 3'(s); #1;
      chk("pin_reset_val", int'(stateValue), s);
    end
    chk("pin_reset_low", int'(low_flags), 7'b0000011);
    chk("pin_reset_any_low", int'(any_low), 1);
    chk("pin_reset_all_zero", int'(all_zero), 0);
    chk("pin_reset_sat", int'(sat_evt), 0);

    // Saturation at zero
    state = 3'd0; DownState = 1'b1;
    repeat (3) begin
      edge1();
      chk("pin_sat_low_val", int'(stateValue), 0);
      chk("pin_sat_low_evt", int'(sat_evt), 1);
    end
    clr();
    // Saturation at the top
    state = 3'd6; UpState = 1'b1;
    edge1();
    chk("pin_sat_hi_val1", int'(stateValue), 7);
    chk("pin_sat_hi_evt1", int'(sat_evt), 0);
    edge1();
    chk("pin_sat_hi_val2", int'(stateValue), 7);
    chk("pin_sat_hi_evt2", int'(sat_evt), 1);
    clr();
    // Simultaneous up and down
    state = 3'd3; UpState = 1'b1; DownState = 1'b1;
    edge1();
    chk("pin_both_val", int'(stateValue), 3);
    chk("pin_both_evt", int'(sat_evt), 0);
    clr();
    // Load beats up
    state = 3'd2; wr_en = 1'b1; wr_data = 3'd5; UpState = 1'b1;
    edge1();
    chk("pin_load_val", int'(stateValue), 5);
    chk("pin_load_low2", int'(low_flags[2]), 0);
    chk("pin_load_sat", int'(sat_evt), 0);
    clr();
    // Out-of-range select is ignored
    state = 3'd7; UpState = 1'b1; wr_en = 1'b1; wr_data = 3'd0; #1;
    chk("pin_oor_read", int'(stateValue), 0);
    edge1();
    clr();
    state = 3'd5; #1;
    chk("pin_oor_nochange", int'(stateValue), 5);

`ifdef TAMA_STATS_DECAY_EN
    // Decay from reset: tick on the fourth edge after release
    Reset = 1'b0; decay_en = 1'b1;
    edge1();
    Reset = 1'b1;
    repeat (3) edge1();
    state = 3'd5; #1;
    chk("pin_decay_before", int'(stateValue), 5);
    state = 3'd4; UpState = 1'b1;
    edge1();
    clr();
    chk("pin_decay_up_cancel", int'(stateValue), 4);
    state = 3'd5; #1;
    chk("pin_decay_ch5", int'(stateValue), 4);
    state = 3'd1; #1;
    chk("pin_decay_ch1", int'(stateValue), 0);
    decay_en = 1'b0;
    repeat (10) edge1();
    state = 3'd5; #1;
    chk("pin_decay_hold", int'(stateValue), 4);
    // Reset coinciding with a tick and an up request
    decay_en = 1'b1;
    repeat (3) edge1();
    state = 3'd4; UpState = 1'b1; Reset = 1'b0;
    edge1();
    Reset = 1'b1; clr();
    chk("pin_rst_mid_ch4", int'(stateValue), 4);
    state = 3'd5;
    repeat (3) edge1();
    chk("pin_rst_mid_no_tick", int'(stateValue), 5);
    edge1();
    chk("pin_rst_mid_tick", int'(stateValue), 4);
    decay_en = 1'b0;
`endif

    // Death: load every channel to zero
    wr_en = 1'b1; wr_data = 3'd0;
    for (int s = 0; s < N; s++) begin
      state = 3'(s);
      edge1();
    end
    clr();
    chk("pin_dead_all_zero", int'(all_zero), 1);
    chk("pin_dead_any_low", int'(any_low), 1);
    chk("pin_dead_low", int'(low_flags), 7'h7f);

    // Randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      Reset = ($urandom_range(0, 99) != 0);
      state = 3'($urandom_range(0, 7));
      UpState = ($urandom_range(0, 2) == 0);
      DownState = ($urandom_range(0, 2) == 0);
      wr_en = ($urandom_range(0, 7) == 0);
      wr_data = 3'($urandom_range(0, 7));
      decay_en = ($urandom_range(0, 3) != 0);
      edge1();
    end
    Reset = 1'b1; clr();
    edge1();
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tamagotchi_stat_bank.md
# tamagotchi_stat_bank

- Parametrised bank of saturating pet-status registers: hunger, energy, mood and similar.
- Generalises the fixed 7×3-bit state register to any channel count and width, with several additions:
  - configurable step;
  - direct load;
  - saturation events;
  - low-level flags;
  - optional automatic periodic decay.
- Sits between the Tamagotchi control FSM (which issues up/down/load requests per stat) and the display/alert logic (which reads values and flags).

## Interface

Parameters:
- NUM_STATS, 7: number of status channels.
- WIDTH, 3: bits per channel.
- IDX_W, 3: select width; must satisfy 2^IDX_W ≥ NUM_STATS.
- STEP, 1: magnitude of one up/down request, 1..MAX_VAL.
- MAX_VAL, 2^WIDTH-1: upper saturation bound.
- INIT_VAL, 0: packed NUM_STATS*WIDTH reset values; channel i occupies bits [i*WIDTH +: WIDTH].
- LOW_THRESH, 1: a channel is "low" when its value ≤ LOW_THRESH.
- DECAY_PERIOD, 1000: cycles between decay ticks, ≥ 2.

Ports:
- clk, in, 1: single clock, rising edge.
- Reset, in, 1: synchronous, active-low reset.
- state, in, IDX_W: channel select for read, up/down and load.
- UpState, in, 1: add STEP to the selected channel.
- DownState, in, 1: subtract STEP from the selected channel.
- wr_en, in, 1: load wr_data into the selected channel.
- wr_data, in, WIDTH: load value; clipped to MAX_VAL.
- decay_en, in, 1: enables the decay timer; gating input only.
- stateValue, out, WIDTH: combinational read of the selected channel.
- low_flags, out, NUM_STATS: registered; bit i set when channel i ≤ LOW_THRESH.
- any_low, out, 1: registered OR of low_flags.
- all_zero, out, 1: registered; every channel equals 0 ("pet dead").
- sat_evt, out, 1: registered one-cycle pulse when a request was clipped.

## Operation

- Storage: NUM_STATS registers of WIDTH bits.
- Reset (Reset=0 at a clk edge):
  - every channel loads INIT_VAL;
  - decay counter clears to 0;
  - sat_evt=0;
  - low_flags, any_low and all_zero take the values computed from INIT_VAL.
- Per edge with Reset=1, the next value of channel i is computed as follows:
  - If wr_en and state==i: next = min(wr_data, MAX_VAL). Load overrides up/down and decay on that channel.
  - Otherwise, compute a signed delta:
    - +STEP if UpState and state==i;
    - −STEP if DownState and state==i;
    - 0 if both are high or neither is;
    - −1 added if a decay tick occurs this cycle.
  - next = clamp(value+delta, 0, MAX_VAL). Use a WIDTH+2-bit signed intermediate; no wrap-around ever.
- sat_evt is set at the edge only when a user up/down request (not decay) was clipped on the selected channel.
- state ≥ NUM_STATS:
  - up/down/load requests are ignored;
  - stateValue=0;
  - decay still applies to all channels.
- Flags are computed from the next values and registered at the same edge, so they always match the stored values.

## Timing

- Write latency: 1 cycle; stateValue reflects an update immediately after the edge.
- Read latency: 0 (combinational mux on state).
- Flags and sat_evt: valid in the same cycle as the stored value they describe.
- Decay counter:
  - counts 0..DECAY_PERIOD-1 while decay_en=1 and holds while decay_en=0;
  - the tick is asserted in the cycle the counter equals DECAY_PERIOD-1, and the counter returns to 0 at that edge.
- Reset mid-operation: reset wins over all requests in that cycle; a pending decay tick is discarded.

## Configuration

- Macro: TAMA_STATS_DECAY_EN.
- Defined: the decay counter and tick logic are built as described.
- Undefined:
  - no counter is synthesised;
  - decay_en remains a port but is ignored;
  - the tick is constant 0;
  - all other behaviour is unchanged.

## Test plan

Common setup: NUM_STATS=7, WIDTH=3, STEP=1, LOW_THRESH=1, INIT_VAL channel i = i, DECAY_PERIOD=4, TAMA_STATS_DECAY_EN defined.

- Reset check: hold Reset=0 for 1 edge, then sweep state 0..6 → stateValue reads 0..6; low_flags=7'b0000011; any_low=1; all_zero=0; sat_evt=0.
- Saturation at both bounds:
  - state=0 with DownState for 3 edges → value stays 0 and sat_evt pulses after each edge;
  - state=6 with UpState for 2 edges → 7, then 7 with sat_evt=1 on the second edge.
- Simultaneous requests: state=3 with UpState=DownState=1 → value stays 3, sat_evt=0.
- Load priority: state=2, wr_en=1, wr_data=5, UpState=1 → value 5, low_flags bit2 clears.
- Decay:
  - decay_en=1 from reset → after 4 edges every nonzero channel drops by 1;
  - UpState on state=4 during the tick → channel 4 unchanged.
  - With decay_en=0, values hold indefinitely.
- Reset mid-operation: drive UpState and a coinciding decay tick, with Reset=0 on that edge → INIT_VAL restored, counter=0, next tick 4 cycles after Reset releases.
- Death: load all channels to 0 → all_zero=1 and any_low=1 one edge later.
